// File: rtl/port_pkg.sv
// Shared pitch-word definitions for the PORT glide generator and its downstream NCO.
// Pitch word layout: {base increment, octave shift}.
package port_pkg;

    localparam int unsigned PITCH_W = 16;
    localparam int unsigned BASE_W  = 13;
    localparam int unsigned OCT_W   = 3;

    typedef struct packed {
        logic [BASE_W-1:0] base;
        logic [OCT_W-1:0]  oct;
    } pitch_t;

    // Largest result is 0x1FFF << 7 = 0xFFF80, so any accumulator of 20 bits or more holds it.
    function automatic logic [31:0] pitch_to_inc(input logic [PITCH_W-1:0] pitch,
                                                 input int unsigned        acc_w);
        pitch_t      p;
        logic [31:0] inc;
        p   = pitch_t'(pitch);
        inc = 32'(p.base) << p.oct;
        if (acc_w < 32) begin
            inc = inc & ((32'd1 << acc_w) - 32'd1);
        end
        return inc;
    endfunction

endpackage

// File: rtl/nco_prescaler.sv
// Free-running sample-rate divider: counts 0..DIV-1 and emits a registered
// one-clock tick on each wrap. Reusable by any sample-rate stage.
module nco_prescaler #(
    parameter int unsigned DIV = 256
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             tick_q;
    logic             tick_d;

    always_comb begin
        cnt_d  = cnt_q + CNT_W'(1);
        tick_d = 1'b0;
        if (cnt_q == CNT_LAST) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/port_nco.sv
// Tick-rate NCO fed by the PORT pitch word: sawtooth, PWM square and wrap strobe.
// Define PORT_NCO_TRI_OUT_EN to add the TRI_OUT triangle output.
module port_nco
    import port_pkg::*;
#(
    parameter int unsigned ACC_W = 24,
    parameter int unsigned DIV   = 256,
    parameter int unsigned OUT_W = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PITCH_W-1:0] GEN_IN,
    input  logic [OUT_W-1:0]   PW,
    input  logic               SYNC_IN,
    output logic               TICK_OUT,
    output logic [OUT_W-1:0]   SAW_OUT,
    output logic               SQR_OUT,
`ifdef PORT_NCO_TRI_OUT_EN
    output logic [OUT_W-1:0]   TRI_OUT,
`endif
    output logic               WRAP_OUT
);

    logic             tick;
    logic [ACC_W-1:0] inc;
    logic [ACC_W-1:0] acc_sum;
    logic             carry;
    logic             sync_rise;

    logic [ACC_W-1:0] acc_q,     acc_d;
    logic [OUT_W-1:0] saw_q,     saw_d;
    logic             sqr_q,     sqr_d;
    logic             wrap_q,    wrap_d;
    logic             sync_in_q;
    logic             sync_pend_q, sync_pend_d;
`ifdef PORT_NCO_TRI_OUT_EN
    logic [OUT_W-1:0] tri_q,     tri_d;
`endif

    nco_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign inc                = ACC_W'(pitch_to_inc(GEN_IN, ACC_W));
    assign {carry, acc_sum}   = {1'b0, acc_q} + {1'b0, inc};
    assign sync_rise          = SYNC_IN & ~sync_in_q;

    always_comb begin
        acc_d       = acc_q;
        saw_d       = saw_q;
        sqr_d       = sqr_q;
        wrap_d      = 1'b0;
        sync_pend_d = sync_pend_q | sync_rise;
`ifdef PORT_NCO_TRI_OUT_EN
        tri_d       = tri_q;
`endif
        if (tick) begin
            // A pending sync overrides the add; an edge arriving in this same cycle
            // is kept pending for the following tick.
            if (sync_pend_q) begin
                acc_d       = '0;
                sync_pend_d = sync_rise;
            end else begin
                acc_d  = acc_sum;
                wrap_d = carry;
            end
            saw_d = acc_d[ACC_W-1 -: OUT_W];
            sqr_d = (saw_d < PW);
`ifdef PORT_NCO_TRI_OUT_EN
            tri_d = acc_d[ACC_W-1] ? ~acc_d[ACC_W-2 -: OUT_W] : acc_d[ACC_W-2 -: OUT_W];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            saw_q       <= '0;
            sqr_q       <= 1'b0;
            wrap_q      <= 1'b0;
            sync_in_q   <= 1'b0;
            sync_pend_q <= 1'b0;
`ifdef PORT_NCO_TRI_OUT_EN
            tri_q       <= '0;
`endif
        end else begin
            acc_q       <= acc_d;
            saw_q       <= saw_d;
            sqr_q       <= sqr_d;
            wrap_q      <= wrap_d;
            sync_in_q   <= SYNC_IN;
            sync_pend_q <= sync_pend_d;
`ifdef PORT_NCO_TRI_OUT_EN
            tri_q       <= tri_d;
`endif
        end
    end

    assign TICK_OUT = tick;
    assign SAW_OUT  = saw_q;
    assign SQR_OUT  = sqr_q;
    assign WRAP_OUT = wrap_q;
`ifdef PORT_NCO_TRI_OUT_EN
    assign TRI_OUT  = tri_q;
`endif

endmodule

// File: tb/tb_port_nco.sv
// Directed bench for port_nco at DIV=4, ACC_W=24, OUT_W=12.
module tb_port_nco;

    localparam int unsigned DIV_TB = 4;

    logic        clk;
    logic        rst;
    logic [15:0] gen;
    logic [11:0] pw;
    logic        sync_in;
    logic        tick_out;
    logic [11:0] saw_out;
    logic        sqr_out;
    logic        wrap_out;
`ifdef PORT_NCO_TRI_OUT_EN
    logic [11:0] tri_out;
`endif

    int n_cmp = 0;
    int n_err = 0;

    port_nco #(
        .ACC_W (24),
        .DIV   (DIV_TB),
        .OUT_W (12)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .GEN_IN   (gen),
        .PW       (pw),
        .SYNC_IN  (sync_in),
        .TICK_OUT (tick_out),
        .SAW_OUT  (saw_out),
        .SQR_OUT  (sqr_out),
`ifdef PORT_NCO_TRI_OUT_EN
        .TRI_OUT  (tri_out),
`endif
        .WRAP_OUT (wrap_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          do_rst;
        logic [15:0] gen;
        logic [11:0] pw;
        int          ticks;
        logic [23:0] acc;
        logic [11:0] saw;
        logic        sqr;
        int          wraps;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Wait (bounded) for the tick cycle, then step past the tick edge.
    task automatic tick_step();
        bit found;
        found = 1'b0;
        for (int n = 0; n < 3 * int'(DIV_TB); n++) begin
            @(negedge clk);
            if (tick_out === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            n_cmp++;
            n_err++;
            $display("FAIL tick_timeout: got no TICK_OUT, want one within %0d clk", 3 * DIV_TB);
        end else begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1);
    end

    initial begin
        int wraps;
        rst     = 1'b1;
        gen     = '0;
        pw      = '0;
        sync_in = 1'b0;

        vecs[0] = '{1'b1, 16'h0800, 12'h000, 10, 24'h000A00, 12'h000, 1'b0, 0};
        vecs[1] = '{1'b1, 16'h0804, 12'h800, 10, 24'h00A000, 12'h00A, 1'b1, 0};
        vecs[2] = '{1'b0, 16'h0804, 12'h010,  6, 24'h010000, 12'h010, 1'b0, 0};
        vecs[3] = '{1'b1, 16'h0007, 12'hFFF,  5, 24'h000000, 12'h000, 1'b1, 0};
        vecs[4] = '{1'b1, 16'h000F, 12'h001,  3, 24'h000180, 12'h000, 1'b1, 0};
        vecs[5] = '{1'b0, 16'h8007, 12'h009,  2, 24'h100180, 12'h100, 1'b0, 0};
        vecs[6] = '{1'b0, 16'hFFFF, 12'h100, 32, 24'h0FF180, 12'h0FF, 1'b1, 2};

        // Reset state and prescaler cadence
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check("rst_outs", {28'h0, tick_out, sqr_out, wrap_out, |saw_out}, 32'h0);
        end
        rst = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("tick_cadence_%0d", k), {31'h0, tick_out}, {31'h0, (k % 4) == 0});
        end
        check("zero_pitch_acc", {8'h0, dut.acc_q}, 32'h0);

        // Table-driven accumulation vectors
        for (int v = 0; v < 7; v++) begin
            if (vecs[v].do_rst) do_reset();
            gen   = vecs[v].gen;
            pw    = vecs[v].pw;
            wraps = 0;
            for (int t = 0; t < vecs[v].ticks; t++) begin
                tick_step();
                if (wrap_out === 1'b1) wraps++;
            end
            check($sformatf("vec%0d_acc", v), {8'h0, dut.acc_q}, {8'h0, vecs[v].acc});
            check($sformatf("vec%0d_saw", v), {20'h0, saw_out}, {20'h0, vecs[v].saw});
            check($sformatf("vec%0d_sqr", v), {31'h0, sqr_out}, {31'h0, vecs[v].sqr});
            check($sformatf("vec%0d_wraps", v), wraps, vecs[v].wraps);
        end

        // Overflow at tick 17 with maximum increment
        do_reset();
        gen = 16'hFFFF;
        pw  = 12'h000;
        for (int t = 1; t <= 17; t++) begin
            tick_step();
            check($sformatf("wrap_t%0d", t), {31'h0, wrap_out}, {31'h0, t == 17});
        end
        check("wrap_acc", {8'h0, dut.acc_q}, 32'h0FF780);
        check("wrap_saw", {20'h0, saw_out}, 32'h0FF);
        @(posedge clk);
        #1;
        check("wrap_one_clk", {31'h0, wrap_out}, 32'h0);

        // Square thresholds around SAW=0x800
        do_reset();
        gen = 16'h8007;
        pw  = 12'h801;
        repeat (16) tick_step();
        check("sq_acc", {8'h0, dut.acc_q}, 32'h800000);
        check("sq_saw", {20'h0, saw_out}, 32'h800);
        check("sq_pw801", {31'h0, sqr_out}, 32'h1);
`ifdef PORT_NCO_TRI_OUT_EN
        check("tri_peak", {20'h0, tri_out}, 32'hFFF);
`endif
        gen = 16'h0000;
        pw  = 12'h800;
        tick_step();
        check("sq_pw800", {31'h0, sqr_out}, 32'h0);
        check("sq_frozen", {8'h0, dut.acc_q}, 32'h800000);
        pw = 12'h000;
        for (int t = 0; t < 3; t++) begin
            tick_step();
            check($sformatf("sq_pw0_%0d", t), {31'h0, sqr_out}, 32'h0);
        end
        pw = 12'hFFF;
        tick_step();
        check("sq_pwfff", {31'h0, sqr_out}, 32'h1);

        // Two sync edges between ticks collapse into one
        do_reset();
        gen = 16'h0804;
        pw  = 12'h000;
        repeat (3) tick_step();
        check("sync_pre", {8'h0, dut.acc_q}, 32'h003000);
        sync_in = 1'b1;
        @(posedge clk); #1;
        sync_in = 1'b0;
        @(posedge clk); #1;
        sync_in = 1'b1;
        @(posedge clk); #1;
        sync_in = 1'b0;
        tick_step();
        check("sync2_acc", {8'h0, dut.acc_q}, 32'h0);
        check("sync2_wrap", {31'h0, wrap_out}, 32'h0);
        check("sync2_saw", {20'h0, saw_out}, 32'h0);
        tick_step();
        check("sync2_once", {8'h0, dut.acc_q}, 32'h001000);

        // Sync beats a simultaneous overflow
        do_reset();
        gen = 16'hFFFF;
        repeat (16) tick_step();
        sync_in = 1'b1;
        @(posedge clk); #1;
        sync_in = 1'b0;
        tick_step();
        check("sync_ovf_acc", {8'h0, dut.acc_q}, 32'h0);
        check("sync_ovf_wrap", {31'h0, wrap_out}, 32'h0);
        tick_step();
        check("sync_ovf_next", {8'h0, dut.acc_q}, 32'h0FFF80);

        // Sync edge landing in the tick cycle is served one tick later
        do_reset();
        gen = 16'h0804;
        tick_step();
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("tickcyc_tick", {31'h0, tick_out}, 32'h1);
        sync_in = 1'b1;
        @(posedge clk); #1;
        check("tickcyc_acc", {8'h0, dut.acc_q}, 32'h002000);
        sync_in = 1'b0;
        tick_step();
        check("tickcyc_served", {8'h0, dut.acc_q}, 32'h0);
        tick_step();
        check("tickcyc_after", {8'h0, dut.acc_q}, 32'h001000);

        // Pitch glitch between ticks is ignored
        do_reset();
        gen = 16'h0804;
        repeat (2) tick_step();
        @(posedge clk); #1;
        gen = 16'hFFFF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        gen = 16'h0804;
        tick_step();
        check("glitch_acc", {8'h0, dut.acc_q}, 32'h003000);
        check("glitch_wrap", {31'h0, wrap_out}, 32'h0);

        // Reset with a sync pending discards it
        sync_in = 1'b1;
        @(posedge clk); #1;
        sync_in = 1'b0;
        rst     = 1'b1;
        @(posedge clk); #1;
        check("midrst_acc", {8'h0, dut.acc_q}, 32'h0);
        check("midrst_outs", {28'h0, tick_out, sqr_out, wrap_out, |saw_out}, 32'h0);
        rst = 1'b0;
        tick_step();
        check("midrst_t1", {8'h0, dut.acc_q}, 32'h001000);
        tick_step();
        check("midrst_t2", {8'h0, dut.acc_q}, 32'h002000);
        check("midrst_saw", {20'h0, saw_out}, 32'h002);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
